// File: rtl/fpu_seq.sv
// fpu_seq: hands one request at a time to a downstream FPU and returns its result, with a mul wait/timeout.
// Optional macro FPU_SEQ_MULCNT_EN adds a 16-bit wrapping count of completed multiplies on mul_count.

module fpu_seq #(
    parameter int unsigned LOG_BIT = 5,
    parameter int unsigned EXP_BIT = 8,
    parameter int unsigned N_BIT   = 1 << LOG_BIT,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [N_BIT-1:0] req_a,
    input  logic [N_BIT-1:0] req_b,
    input  logic [1:0]       req_op,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [N_BIT-1:0] resp_data,
    output logic             resp_err,
    output logic [N_BIT-1:0] fpu_a,
    output logic [N_BIT-1:0] fpu_b,
    output logic [1:0]       fpu_op,
    input  logic [N_BIT-1:0] fpu_out,
    input  logic             fpu_ready,
    output logic             busy
`ifdef FPU_SEQ_MULCNT_EN
    ,
    output logic [15:0]      mul_count
`endif
);

    localparam int unsigned WAIT_W = 8;
    localparam int unsigned CNT_W  = 16;
    localparam logic [1:0]  OP_MUL = 2'b10;
    localparam logic [1:0]  OP_ABS = 2'b11;

    if (TIMEOUT < 2 || TIMEOUT > 255 || EXP_BIT >= N_BIT) begin : g_param_check
        $error("fpu_seq: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [N_BIT-1:0]  a_q, a_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [N_BIT-1:0]  data_q, data_d;
    logic              err_q, err_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              busy_q, busy_d;
    logic [1:0]        fpu_op_q, fpu_op_d;
    logic              capture_c;

    // First mul cycle sees a stale fpu_ready from before the op change, so it is never trusted.
    assign capture_c = (state_q == ST_EXEC) &&
                       ((op_q != OP_MUL) || ((wait_q != '0) && fpu_ready));

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        wait_d  = wait_q;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = req_op;
                    wait_d  = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                wait_d = wait_q + WAIT_W'(1);
                if (capture_c) begin
                    data_d  = fpu_out;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    data_d  = '1;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
        busy_d       = (state_d != ST_IDLE);
        // Parking fpu_op at abs outside EXEC guarantees an op change on every EXEC entry.
        fpu_op_d     = (state_d == ST_EXEC) ? op_d : OP_ABS;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            wait_q       <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            fpu_op_q     <= OP_ABS;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            wait_q       <= wait_d;
            data_q       <= data_d;
            err_q        <= err_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            fpu_op_q     <= fpu_op_d;
        end
    end

`ifdef FPU_SEQ_MULCNT_EN
    logic [CNT_W-1:0] mulcnt_q;

    // Counts only multiplies whose result was captured; timeouts are excluded.
    always_ff @(posedge clk) begin
        if (rst) begin
            mulcnt_q <= '0;
        end else if (capture_c && (op_q == OP_MUL)) begin
            mulcnt_q <= mulcnt_q + CNT_W'(1);
        end
    end

    assign mul_count = mulcnt_q;
`endif

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = data_q;
    assign resp_err   = err_q;
    assign busy       = busy_q;
    assign fpu_a      = a_q;
    assign fpu_b      = b_q;
    assign fpu_op     = fpu_op_q;

endmodule

// File: tb/tb_fpu_seq.sv
// tb_fpu_seq: scoreboard bench for fpu_seq with a behavioural FPU (configurable mul latency / stall).
// Define FPU_SEQ_MULCNT_EN to also check mul_count.

module tb_fpu_seq;

    localparam int unsigned NB = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [NB-1:0] req_a, req_b;
    logic [1:0]    req_op;
    logic          resp_valid;
    logic          resp_ready;
    logic [NB-1:0] resp_data;
    logic          resp_err;
    logic [NB-1:0] fpu_a, fpu_b, fpu_out;
    logic [1:0]    fpu_op;
    logic          fpu_ready;
    logic          busy;
`ifdef FPU_SEQ_MULCNT_EN
    logic [15:0]   mul_count;
`endif

    always #5 clk = ~clk;

    fpu_seq #(.LOG_BIT(5), .EXP_BIT(8), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_op     (fpu_op),
        .fpu_out    (fpu_out),
        .fpu_ready  (fpu_ready),
        .busy       (busy)
`ifdef FPU_SEQ_MULCNT_EN
        , .mul_count(mul_count)
`endif
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Single-precision <-> real helpers (normal numbers, truncating rounding).
    function automatic real f2r(input logic [31:0] f);
        real m;
        int  e;
        e = int'(f[30:23]);
        if (e == 0) return 0.0;
        m = (1.0 + real'(int'(f[22:0])) / 8388608.0) * (2.0 ** (e - 127));
        return f[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int          e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        if (e <= 0) return {d[63], 31'h0};
        if (e >= 255) return {d[63], 8'hFF, 23'h0};
        return {d[63], 8'(e), d[51:29]};
    endfunction

    function automatic logic [31:0] fp_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return r2f(f2r(a) - f2r(b));
            2'b01:   return r2f(f2r(a) + f2r(b));
            2'b10:   return r2f(f2r(a) * f2r(b));
            default: return {1'b0, a[30:0]};
        endcase
    endfunction

    // Behavioural downstream FPU: mul restarts on any fpu_op change and completes after fpu_lat cycles.
    int          fpu_lat   = 1;
    bit          fpu_stall = 1'b0;
    logic [1:0]  prev_op   = 2'b11;
    int          fcnt      = 0;
    bit          frdy      = 1'b0;
    logic [31:0] mul_q     = 32'h0;

    always @(posedge clk) begin
        if (fpu_op != prev_op) begin
            fcnt <= 0;
            frdy <= 1'b0;
        end else if (!frdy) begin
            if (fcnt == fpu_lat - 1) begin
                frdy  <= 1'b1;
                mul_q <= fp_op(fpu_a, fpu_b, 2'b10);
            end
            fcnt <= fcnt + 1;
        end
        prev_op <= fpu_op;
    end

    assign fpu_ready = frdy && !fpu_stall;
    assign fpu_out   = (fpu_op == 2'b10) ? mul_q : fp_op(fpu_a, fpu_b, fpu_op);

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [1:0]  op;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];

    // Reference: arithmetic result, or all-ones error when the mul cannot finish inside TIMEOUT EXEC cycles.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                                   input int lat, input bit stall);
        exp_t e;
        e.op  = op;
        e.acc = 0;
        e.err = 1'b0;
        e.data = fp_op(a, b, op);
        if (op != 2'b10) begin
            e.lat = 2;
        end else if (stall || lat + 1 > int'(TO) - 1) begin
            e.data = 32'hFFFF_FFFF;
            e.err  = 1'b1;
            e.lat  = int'(TO) + 1;
        end else begin
            e.lat = lat + 3;
        end
        return e;
    endfunction

    int rr_mode = 2;  // 0 random, 1 hold low, 2 always high

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       resp_ready = 1'($urandom_range(0, 1));
            1:       resp_ready = 1'b0;
            default: resp_ready = 1'b1;
        endcase
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                         input int lat, input bit stall,
                         input bit has_exp, input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        int   waitc;
        waitc = 0;
        @(negedge clk);
        while (!req_ready) begin
            @(negedge clk);
            waitc++;
            if (waitc > 200) begin
                checks++;
                failures++;
                $display("FAIL issue_wait req_ready stuck low actual=0 required=1");
                return;
            end
        end
        fpu_lat   = lat;
        fpu_stall = stall;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_valid = 1'b1;
        e = model(a, b, op, lat, stall);
        if (has_exp) begin
            e.data = exp_data;
            e.err  = exp_err;
        end
        e.acc = cyc;
        exp_q.push_back(e);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    exp_t mon_e;
    bit   mon_seen   = 1'b0;
    int   mulcnt_exp = 0;

    // Monitor: compares every RESP cycle (so held data must stay stable) and pops on handshake.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                mon_e = exp_q[0];
                chk("resp_data", resp_data, mon_e.data);
                chk("resp_err", 32'(resp_err), 32'(mon_e.err));
                chk("fpu_op_in_resp", 32'(fpu_op), 32'd3);
                chk("req_ready_in_resp", 32'(req_ready), 32'd0);
                chk("busy_in_resp", 32'(busy), 32'd1);
                if (!mon_seen) chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                mon_seen = 1'b1;
                if (resp_ready) begin
                    void'(exp_q.pop_front());
                    mon_seen = 1'b0;
                    if (mon_e.op == 2'b10 && !mon_e.err) mulcnt_exp++;
`ifdef FPU_SEQ_MULCNT_EN
                    chk("mul_count", 32'(mul_count), 32'(16'(mulcnt_exp)));
`endif
                end
            end
        end
    end

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        mon_seen   = 1'b0;
        mulcnt_exp = 0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_fpu_op"}, 32'(fpu_op), 32'd3);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    endtask

    function automatic logic [31:0] rnd_f();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check_idle("reset");
        chk("reset_resp_data", resp_data, 32'h0);
        chk("reset_fpu_a", fpu_a, 32'h0);
        chk("reset_fpu_b", fpu_b, 32'h0);
`ifdef FPU_SEQ_MULCNT_EN
        chk("reset_mul_count", 32'(mul_count), 32'd0);
`endif

        // Directed arithmetic with known IEEE results.
        issue(32'h3FC0_0000, 32'h4000_0000, 2'b01, 1, 1'b0, 1'b1, 32'h4060_0000, 1'b0);
        drain();
        issue(32'h4000_0000, 32'h3FC0_0000, 2'b00, 1, 1'b0, 1'b1, 32'h3F00_0000, 1'b0);
        drain();
        issue(32'hC040_0000, 32'h0000_0000, 2'b11, 1, 1'b0, 1'b1, 32'h4040_0000, 1'b0);
        drain();
        issue(32'h4040_0000, 32'h4000_0000, 2'b10, 2, 1'b0, 1'b1, 32'h40C0_0000, 1'b0);
        issue(32'h4000_0000, 32'h4000_0000, 2'b10, 1, 1'b0, 1'b1, 32'h4080_0000, 1'b0);
        drain();
`ifdef FPU_SEQ_MULCNT_EN
        chk("mul_count_two", 32'(mul_count), 32'd2);
`endif

        // Timeout with a stalled FPU, then the latency boundary on each side.
        issue(32'h4040_0000, 32'h4000_0000, 2'b10, 1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1);
        drain();
        issue(32'h4040_0000, 32'h4040_0000, 2'b10, int'(TO) - 2, 1'b0, 1'b1, 32'h4110_0000, 1'b0);
        drain();
        issue(32'h4040_0000, 32'h4040_0000, 2'b10, int'(TO) - 1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        drain();

        // Held response must stay stable while resp_ready is low.
        rr_mode = 1;
        issue(32'h3FC0_0000, 32'h4000_0000, 2'b01, 1, 1'b0, 1'b0, 32'h0, 1'b0);
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("hold_valid", 32'(resp_valid), 32'd1);
        rr_mode = 2;
        drain();

        // Requests arriving outside IDLE are ignored.
        issue(32'h4000_0000, 32'h4040_0000, 2'b10, 5, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_a     = 32'h1234_5678;
            req_b     = 32'h8765_4321;
            req_op    = 2'b01;
            chk("busy_req_ready", 32'(req_ready), 32'd0);
            chk("busy_fpu_a", fpu_a, 32'h4000_0000);
        end
        @(negedge clk);
        req_valid = 1'b0;
        drain();

        // Reset in the second EXEC cycle of a mul, and reset while a response is held.
        issue(32'h4040_0000, 32'h4000_0000, 2'b10, 1, 1'b1, 1'b0, 32'h0, 1'b0);
        pulse_reset();
        check_idle("rst_exec");
        rr_mode = 1;
        issue(32'h3FC0_0000, 32'h4000_0000, 2'b01, 1, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        pulse_reset();
        check_idle("rst_resp");
        repeat (4) @(negedge clk);
        chk("rst_resp_quiet", 32'(resp_valid), 32'd0);

        // Randomized traffic with random backpressure and FPU latency.
        rr_mode = 0;
        for (int i = 0; i < 60; i++) begin
            issue(rnd_f(), rnd_f(), 2'($urandom_range(0, 3)), int'($urandom_range(1, TO - 1)),
                  ($urandom_range(0, 7) == 0), 1'b0, 32'h0, 1'b0);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpu_seq.md
FPU_SEQ -- requirements
Module: fpu_seq

Interface
REQ-001 SHALL have parameter LOG_BIT, default 5, log2 of word width.
REQ-002 SHALL have parameter EXP_BIT, default 8, exponent width.
REQ-003 SHALL have parameter N_BIT, default 1<<LOG_BIT, word width (derived, not overridden).
REQ-004 SHALL have parameter TIMEOUT, default 64, max EXEC cycles before error (range 2..255).
REQ-005 SHALL have port clk, input, 1, single clock, all logic on posedge.
REQ-006 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-007 SHALL have port req_valid, input, 1, request present.
REQ-008 SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-009 SHALL have ports req_a and req_b, input, N_BIT each, operands.
REQ-010 SHALL have port req_op, input, 2, op: 00 sub, 01 add, 10 mul, 11 abs(a).
REQ-011 SHALL have port resp_valid, output, 1, result present.
REQ-012 SHALL have port resp_ready, input, 1, consumer takes result.
REQ-013 SHALL have port resp_data, output, N_BIT, result.
REQ-014 SHALL have port resp_err, output, 1, result is a timeout error.
REQ-015 SHALL have ports fpu_a, fpu_b, fpu_op, outputs, N_BIT/N_BIT/2, drive downstream FPU.
REQ-016 SHALL have ports fpu_out and fpu_ready, inputs, N_BIT/1, FPU result and ready.
REQ-017 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-018 SHALL implement states IDLE, EXEC, RESP.
REQ-019 SHALL assert req_ready only in IDLE.
REQ-020 SHALL, on req_valid && req_ready, register a, b, op into operand registers and enter EXEC next cycle.
REQ-021 SHALL drive fpu_a/fpu_b from operand registers at all times; fpu_op = latched op in EXEC, 2'b11 in IDLE and RESP, so every EXEC entry changes fpu_op and restarts the FPU multiplier.
REQ-022 SHALL keep an 8-bit wait counter, cleared on EXEC entry and incremented each EXEC cycle.
REQ-023 SHALL, for non-mul ops, capture fpu_out into resp_data in the first EXEC cycle (resp_valid high 2 cycles after acceptance).
REQ-024 SHALL, for mul, ignore fpu_ready in the first EXEC cycle (stale) and capture fpu_out on the first later cycle with fpu_ready=1.
REQ-025 SHALL, if wait counter reaches TIMEOUT-1 without capture, load resp_data all-ones, set resp_err=1, enter RESP.
REQ-026 SHALL in RESP hold resp_valid=1, resp_data, resp_err stable until resp_ready=1, then return to IDLE next cycle; resp_err clears on that transition.
REQ-027 SHALL ignore req_valid outside IDLE; no request is queued.
REQ-028 SHALL deassert resp_valid in every state except RESP.

Reset
REQ-029 SHALL on rst force IDLE, resp_valid=0, resp_data=0, resp_err=0, wait counter 0, operand registers 0, fpu_op=2'b11.
REQ-030 SHALL abandon any in-flight operation on rst mid-EXEC or mid-RESP; no response is emitted.
REQ-031 SHALL give rst priority over every handshake in the same cycle.

Configuration
REQ-032 SHALL, with FPU_SEQ_MULCNT_EN defined, add output mul_count (16 bits, reset 0), incremented on each successfully captured mul (not timeouts), wrapping 0xFFFF->0x0000.
REQ-033 SHALL, without FPU_SEQ_MULCNT_EN, omit the mul_count port and its counter.

Verification
REQ-034 SHALL cover add with the real fpu: a=0x3FC00000, b=0x40000000, op=01 -> resp_data=0x40600000, resp_err=0, resp_valid exactly 2 cycles after accept.
REQ-035 SHALL cover sub: a=0x40000000, b=0x3FC00000, op=00 -> 0x3F000000.
REQ-036 SHALL cover two back-to-back muls: 0x40400000*0x40000000 then 0x40000000*0x40000000 -> 0x40C00000 then 0x40800000; fpu_op visits 11 between them; mul_count=2 when enabled.
REQ-037 SHALL cover abs: a=0xC0400000, op=11 -> 0x40400000.
REQ-038 SHALL cover timeout with a stub FPU holding fpu_ready=0, op=10, TIMEOUT=8 -> resp_valid=1, resp_err=1, resp_data=0xFFFFFFFF after 8 EXEC cycles.
REQ-039 SHALL cover rst asserted in the second EXEC cycle of a mul -> next cycle IDLE, req_ready=1, resp_valid=0, fpu_op=11; resp_valid held 3 cycles with resp_ready=0 -> data unchanged.
